// File: rtl/bus_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// bus_round_robin_arbiter
//
// Round-robin arbiter for the shared multi-master transaction bus. It grants
// one requester at a time, follows the transaction from begin strobe to end
// or error strobe, and revokes grants that the master never uses. A watchdog
// aborts a transaction that stalls without data. The abort drives the forced
// end and error strobes, which the top level ORs onto the bus. The arbiter
// does not route any data.
//
// Ports:
//   clk_i                  system clock, rising edge
//   rst_i                  synchronous reset, active-high
//   request_i              per-master level request, held until done
//   grant_o                registered one-hot grant, zero when bus is free
//   bus_beginTransaction_i begin strobe from the granted master
//   bus_endTransaction_i   end strobe from slave or master
//   bus_dataValid_i        data-valid strobe, keeps the watchdog quiet
//   bus_error_i            error strobe from slave
//   bus_endTransaction_o   forced end strobe on watchdog abort
//   bus_error_o            forced error strobe on watchdog abort
//   busy_o                 high whenever the arbiter is not idle
//   timeout_count_o        saturating count of watchdog aborts
// ---------------------------------------------------------------------------
module bus_round_robin_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int GRANT_WAIT     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] request_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  input  logic                   bus_beginTransaction_i,
  input  logic                   bus_endTransaction_i,
  input  logic                   bus_dataValid_i,
  input  logic                   bus_error_i,
  output logic                   bus_endTransaction_o,
  output logic                   bus_error_o,
  output logic                   busy_o,
  output logic [7:0]             timeout_count_o
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [PTR_W-1:0] POINTER_RESET = PTR_W'(NUM_MASTERS - 1);
  localparam logic [3:0]       WAIT_LAST     = 4'(GRANT_WAIT - 1);
  localparam logic [7:0]       WATCHDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    BUSY,
    RELEASE
  } arbState_t;

  arbState_t              state, stateNext;
  logic [NUM_MASTERS-1:0] grantQ, grantNext;
  logic [PTR_W-1:0]       pointer, pointerNext;
  logic [3:0]             waitCount, waitCountNext;
  logic [7:0]             watchdog, watchdogNext;
  logic                   forcedStrobe, forcedStrobeNext;
  logic [7:0]             timeoutCount, timeoutCountNext;

  logic                   anyRequest;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       candidate;
  logic                   requestDropped;

  // The search starts one past the last winner, so the master just served
  // ends up with the lowest priority.
  always_comb begin
    anyRequest = 1'b0;
    winner     = pointer;
    candidate  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      candidate = PTR_W'((int'(pointer) + i) % NUM_MASTERS);
      if (!anyRequest && request_i[candidate]) begin
        anyRequest = 1'b1;
        winner     = candidate;
      end
    end
  end

  assign requestDropped = ~|(request_i & grantQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      grantQ       <= '0;
      pointer      <= POINTER_RESET;
      waitCount    <= '0;
      watchdog     <= '0;
      forcedStrobe <= 1'b0;
      timeoutCount <= '0;
    end else begin
      state        <= stateNext;
      grantQ       <= grantNext;
      pointer      <= pointerNext;
      waitCount    <= waitCountNext;
      watchdog     <= watchdogNext;
      forcedStrobe <= forcedStrobeNext;
      timeoutCount <= timeoutCountNext;
    end
  end

  // Next-state logic. The forced strobe is a pulse: it defaults low and is
  // set only on the BUSY->RELEASE transition caused by a watchdog abort, so
  // it is visible during exactly the single RELEASE cycle.
  always_comb begin
    stateNext        = state;
    grantNext        = grantQ;
    pointerNext      = pointer;
    waitCountNext    = waitCount;
    watchdogNext     = watchdog;
    forcedStrobeNext = 1'b0;
    timeoutCountNext = timeoutCount;

    unique case (state)
      IDLE: begin
        grantNext = '0;
        if (anyRequest) begin
          grantNext[winner] = 1'b1;
          pointerNext       = winner;
          waitCountNext     = '0;
          stateNext         = GRANTED;
        end
      end

      GRANTED: begin
        // A begin strobe wins over a request drop in the same cycle.
        if (bus_beginTransaction_i) begin
          watchdogNext = '0;
          stateNext    = BUSY;
        end else if (requestDropped || (waitCount == WAIT_LAST)) begin
          grantNext = '0;
          stateNext = RELEASE;
        end else begin
          waitCountNext = waitCount + 4'd1;
        end
      end

      BUSY: begin
        // Normal completion has priority over a watchdog expiry.
        if (bus_endTransaction_i || bus_error_i) begin
          grantNext = '0;
          stateNext = RELEASE;
        end else if (!bus_dataValid_i && (watchdog == WATCHDOG_LAST)) begin
          grantNext        = '0;
          forcedStrobeNext = 1'b1;
          timeoutCountNext = (timeoutCount == 8'hFF) ? timeoutCount
                                                     : timeoutCount + 8'd1;
          stateNext        = RELEASE;
        end else if (bus_dataValid_i) begin
          watchdogNext = '0;
        end else begin
          watchdogNext = watchdog + 8'd1;
        end
      end

      RELEASE: begin
        grantNext = '0;
        stateNext = IDLE;
      end

      default: begin
        grantNext = '0;
        stateNext = IDLE;
      end
    endcase
  end

  assign grant_o              = grantQ;
  assign bus_endTransaction_o = forcedStrobe;
  assign bus_error_o          = forcedStrobe;
  assign busy_o               = (state != IDLE);
  assign timeout_count_o      = timeoutCount;

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_round_robin_arbiter
//
// Directed bench for the round-robin bus arbiter. It uses four masters, a
// grant wait of 4 and a watchdog limit of 8. Expected grant and abort events
// are queued when each scenario starts. A monitor pops the queue whenever
// the DUT raises a fresh grant or forced strobe. Cycle-exact checks are made
// inline.
// ---------------------------------------------------------------------------
module tb_bus_round_robin_arbiter;

  localparam int NM = 4;
  localparam int GW = 4;
  localparam int TO = 8;

  localparam logic KIND_GRANT = 1'b0;
  localparam logic KIND_ABORT = 1'b1;

  typedef struct packed {
    logic       kind;
    logic [9:0] value;
  } sbEntry_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [NM-1:0] request_i = '0;
  logic          bus_beginTransaction_i = 1'b0;
  logic          bus_endTransaction_i = 1'b0;
  logic          bus_dataValid_i = 1'b0;
  logic          bus_error_i = 1'b0;
  logic [NM-1:0] grant_o;
  logic          bus_endTransaction_o;
  logic          bus_error_o;
  logic          busy_o;
  logic [7:0]    timeout_count_o;

  int            testsRun;
  int            testsFailed;
  sbEntry_t      expQ[$];

  bus_round_robin_arbiter #(
    .NUM_MASTERS   (NM),
    .GRANT_WAIT    (GW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .request_i             (request_i),
    .grant_o               (grant_o),
    .bus_beginTransaction_i(bus_beginTransaction_i),
    .bus_endTransaction_i  (bus_endTransaction_i),
    .bus_dataValid_i       (bus_dataValid_i),
    .bus_error_i           (bus_error_i),
    .bus_endTransaction_o  (bus_endTransaction_o),
    .bus_error_o           (bus_error_o),
    .busy_o                (busy_o),
    .timeout_count_o       (timeout_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Step into the next cycle (just after the rising edge) and drive inputs.
  task automatic applyStimulus(input logic [NM-1:0] req, input logic beginT,
                               input logic endT, input logic dataValid,
                               input logic err);
    @(posedge clk_i);
    #1;
    request_i              = req;
    bus_beginTransaction_i = beginT;
    bus_endTransaction_i   = endT;
    bus_dataValid_i        = dataValid;
    bus_error_i            = err;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushGrant(input logic [NM-1:0] g);
    sbEntry_t e;
    e.kind  = KIND_GRANT;
    e.value = 10'(g);
    expQ.push_back(e);
  endtask

  task automatic pushAbort(input logic [7:0] count);
    sbEntry_t e;
    e.kind  = KIND_ABORT;
    e.value = {1'b1, 1'b1, count};
    expQ.push_back(e);
  endtask

  task automatic compareEvent(input logic kind, input logic [9:0] value,
                              input string name);
    sbEntry_t e;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s: unexpected event kind %0d value 0x%0h, expected none",
               name, kind, value);
    end else begin
      e = expQ.pop_front();
      if (e.kind !== kind || e.value !== value) begin
        testsFailed++;
        $display("[TB] FAIL %s: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                 name, kind, value, e.kind, e.value);
      end
    end
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
  endtask

  // Wait for a grant, begin the next cycle, end endDelay cycles later.
  task automatic runTransaction(input logic [NM-1:0] req, input int endDelay);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(req, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      if (grant_o != '0) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL grantWait: got no grant in 10 cycles, expected a grant");
    end
    applyStimulus(req, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < endDelay; i++) applyStimulus(req, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(req, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: a fresh grant or any forced strobe is an event to score.
  initial begin
    logic [NM-1:0] prevGrant;
    prevGrant = '0;
    forever begin
      @(negedge clk_i);
      if (grant_o != '0 && prevGrant == '0)
        compareEvent(KIND_GRANT, 10'(grant_o), "grantEvent");
      if (bus_endTransaction_o || bus_error_o)
        compareEvent(KIND_ABORT, {bus_endTransaction_o, bus_error_o, timeout_count_o},
                     "abortEvent");
      prevGrant = grant_o;
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Reset state
    rst_i = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("resetGrant", 32'(grant_o), 0);
    checkOutput("resetBusy", 32'(busy_o), 0);
    checkOutput("resetForcedEnd", 32'(bus_endTransaction_o), 0);
    checkOutput("resetForcedErr", 32'(bus_error_o), 0);
    checkOutput("resetTimeoutCount", 32'(timeout_count_o), 0);
    rst_i = 1'b0;

    // Single master 2: grant after 1 cycle, release and idle timing
    pushGrant(4'b0100);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s1GrantCycle0", 32'(grant_o), 0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s1GrantCycle1", 32'(grant_o), 4);
    checkOutput("s1BusyGranted", 32'(busy_o), 1);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s1GrantHeldBusy", 32'(grant_o), 4);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s1ReleaseGrant", 32'(grant_o), 0);
    checkOutput("s1ReleaseBusy", 32'(busy_o), 1);
    checkOutput("s1NoForcedEnd", 32'(bus_endTransaction_o), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s1IdleBusy", 32'(busy_o), 0);

    // All four requesting: rotation 0,1,2,3,0,1 from a fresh pointer
    doReset();
    pushGrant(4'b0001);
    pushGrant(4'b0010);
    pushGrant(4'b0100);
    pushGrant(4'b1000);
    pushGrant(4'b0001);
    pushGrant(4'b0010);
    for (int t = 0; t < 6; t++) runTransaction(4'b1111, 3);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Master 1 never begins: revoked after 4 cycles, master 2 two cycles later
    doReset();
    pushGrant(4'b0010);
    pushGrant(4'b0100);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s3GrantM1", 32'(grant_o), 2);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s3GrantHeldCycle4", 32'(grant_o), 2);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s3Revoked", 32'(grant_o), 0);
    checkOutput("s3NoForcedErr", 32'(bus_error_o), 0);
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s3IdleGap", 32'(grant_o), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s3GrantM2", 32'(grant_o), 4);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s3DropReleases", 32'(grant_o), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s3IdleBusy", 32'(busy_o), 0);

    // Watchdog abort 9 cycles after begin
    doReset();
    pushGrant(4'b0001);
    pushAbort(8'd1);
    pushGrant(4'b0001);
    pushGrant(4'b0001);
    pushGrant(4'b1000);
    pushGrant(4'b0001);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s4NoEarlyAbort", 32'(bus_endTransaction_o), 0);
    checkOutput("s4GrantHeld", 32'(grant_o), 1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s4ForcedEnd", 32'(bus_endTransaction_o), 1);
    checkOutput("s4ForcedErr", 32'(bus_error_o), 1);
    checkOutput("s4TimeoutCount", 32'(timeout_count_o), 1);
    checkOutput("s4GrantDropped", 32'(grant_o), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s4StrobeOneCycle", 32'(bus_endTransaction_o), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // dataValid every 5th cycle keeps the watchdog from firing
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      applyStimulus(4'b0001, 1'b0, 1'b0, (k % 5 == 4), 1'b0);
    @(negedge clk_i);
    checkOutput("s4bStillBusy", 32'(grant_o), 1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s4bNoAbort", 32'(bus_error_o), 0);
    checkOutput("s4bCountKept", 32'(timeout_count_o), 1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // End strobe on the exact expiry cycle: normal completion wins
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s5NoForcedEnd", 32'(bus_endTransaction_o), 0);
    checkOutput("s5NoForcedErr", 32'(bus_error_o), 0);
    checkOutput("s5Released", 32'(grant_o), 0);
    checkOutput("s5CountKept", 32'(timeout_count_o), 1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during BUSY with master 3, then all request: master 0 first
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s6GrantM3", 32'(grant_o), 8);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s6BusyBeforeReset", 32'(busy_o), 1);
    rst_i = 1'b1;
    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("s6ResetGrant", 32'(grant_o), 0);
    checkOutput("s6ResetBusy", 32'(busy_o), 0);
    checkOutput("s6ResetCount", 32'(timeout_count_o), 0);
    checkOutput("s6NoForcedEnd", 32'(bus_endTransaction_o), 0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("s6GrantM0", 32'(grant_o), 1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
